// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state encoding and width helpers for the sequential multiplier
// Purpose: state codes and the iteration-counter width function used by seq_multiplier_ctrl.
// Ports: none (package).
package mul_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // Counter must be able to hold 0..W.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// rtl/ripple_carry_adder.sv - w-bit ripple-carry adder, the multiplier's only arithmetic element
// Purpose: combinational a + b + carry_in with carry out.
// Ports:
//   a_i, b_i     [w-1:0] addends
//   carry_in_i   carry into bit 0
//   sum_o        [w-1:0] sum
//   carry_out_o  carry out of bit w-1
module ripple_carry_adder #(
  parameter int w = 16
) (
  input  logic [w-1:0] a_i,
  input  logic [w-1:0] b_i,
  input  logic         carry_in_i,
  output logic [w-1:0] sum_o,
  output logic         carry_out_o
);

  logic [w:0] carry;

  assign carry[0] = carry_in_i;

  for (genvar i = 0; i < w; i++) begin : g_bit
    assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign carry_out_o = carry[w];

endmodule

// File: rtl/seq_multiplier_ctrl.sv
// rtl/seq_multiplier_ctrl.sv - shift-and-add unsigned multiplier sharing one ripple-carry adder
// Purpose: multi-cycle MUL unit; one add/shift iteration per clock for W clocks.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                begin a multiply (accepted only while ready=1)
//   operand_a/operand_b  [W-1:0] multiplicand / multiplier, captured on accept
//   ready                high in IDLE
//   busy                 high in RUN and DONE
//   done                 one-cycle pulse, product valid from this cycle
//   product              [2W-1:0] result, held until the next completed multiply
module seq_multiplier_ctrl
  import mul_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   operand_a,
  input  logic [W-1:0]   operand_b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CNT_W = cnt_width(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     m_q, m_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     q_q, q_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   product_q, product_d;

  logic [W-1:0]     add_sum;
  logic             add_cout;

  ripple_carry_adder #(.w(W)) u_adder (
    .a_i         (acc_q),
    .b_i         (m_q),
    .carry_in_i  (1'b0),
    .sum_o       (add_sum),
    .carry_out_o (add_cout)
  );

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          m_d     = operand_a;
          q_d     = operand_b;
          acc_d   = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        busy = 1'b1;
        // Add path keeps the adder carry as the new top bit so it lands in
        // ACC[W-1] after the shift. The hold path shifts in C, which is
        // always zero after any shift, so this equals shifting in 1'b0.
        if (q_q[0]) begin
          {c_d, acc_d, q_d} = {add_cout, add_sum, q_q} >> 1;
        end else begin
          {c_d, acc_d, q_d} = {c_q, acc_q, q_q} >> 1;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Capture the final iteration's result so it is visible in DONE.
          product_d = {acc_d, q_d};
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier_ctrl.sv
// tb/tb_seq_multiplier_ctrl.sv - randomized self-checking bench for seq_multiplier_ctrl (W=16 and W=1)
module tb_seq_multiplier_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        sel   = 1'b0;
  logic [15:0] a     = '0;
  logic [15:0] b     = '0;

  logic        r16, bz16, d16;
  logic [31:0] p16;
  logic        r1, bz1, d1;
  logic [1:0]  p1;

  seq_multiplier_ctrl #(.W(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .start     (start && !sel),
    .operand_a (a),
    .operand_b (b),
    .ready     (r16),
    .busy      (bz16),
    .done      (d16),
    .product   (p16)
  );

  seq_multiplier_ctrl #(.W(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start && sel),
    .operand_a (a[0]),
    .operand_b (b[0]),
    .ready     (r1),
    .busy      (bz1),
    .done      (d1),
    .product   (p1)
  );

  wire        cur_ready = sel ? r1  : r16;
  wire        cur_busy  = sel ? bz1 : bz16;
  wire        cur_done  = sel ? d1  : d16;
  wire [31:0] cur_prod  = sel ? {30'b0, p1} : p16;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last16 = '0;
  logic [31:0] last1  = '0;

  // Reference: the product is plain unsigned multiplication of the operands.
  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input logic one);
    if (one) return 32'(x[0] & y[0]);
    return 32'(x) * 32'(y);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one multiply from an IDLE cycle. lat counts edges from the accept
  // edge (1) to the edge after which done is seen. poke re-asserts start
  // with other operands while the unit is busy.
  task automatic do_mul(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] old_prod,
                        input bit poke, output int lat, output logic [31:0] prod,
                        output bit held_ok, output bit busy_ok, output logic done_after,
                        output logic ready_after);
    a = av; b = bv; start = 1'b1;
    tick;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    lat = 1; held_ok = 1'b1; busy_ok = 1'b1;
    while (cur_done !== 1'b1 && lat < 64) begin
      if (cur_prod !== old_prod) held_ok = 1'b0;
      if (cur_busy !== 1'b1 || cur_ready !== 1'b0) busy_ok = 1'b0;
      if (poke && lat >= 2 && lat <= 6) begin
        start = 1'b1; a = 16'd9; b = 16'd9;
      end else begin
        start = 1'b0;
      end
      tick;
      lat++;
    end
    start = 1'b0;
    prod = cur_prod;
    tick;
    done_after  = cur_done;
    ready_after = cur_ready;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0;
    tick; tick;
    rst = 1'b0;
    n_checks++; if (r16 !== 1'b1) $display("FAIL reset_ready16: got %b want 1", r16); else n_pass++;
    n_checks++; if (bz16 !== 1'b0) $display("FAIL reset_busy16: got %b want 0", bz16); else n_pass++;
    n_checks++; if (d16 !== 1'b0) $display("FAIL reset_done16: got %b want 0", d16); else n_pass++;
    n_checks++; if (p16 !== 32'h0) $display("FAIL reset_product16: got %h want 0", p16); else n_pass++;
    n_checks++; if (r1 !== 1'b1) $display("FAIL reset_ready1: got %b want 1", r1); else n_pass++;
    n_checks++; if (p1 !== 2'b00) $display("FAIL reset_product1: got %b want 00", p1); else n_pass++;
    tick;
  endtask

  task automatic test_directed;
    logic [15:0] ta [4] = '{16'd7, 16'hFFFF, 16'h0000, 16'h1234};
    logic [15:0] tb [4] = '{16'd2, 16'hFFFF, 16'h1234, 16'h0000};
    int lat; logic [31:0] prod, expv; bit held, bok; logic da, ra;
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expv = ref_mul(ta[i], tb[i], 1'b0);
      do_mul(ta[i], tb[i], last16, 1'b0, lat, prod, held, bok, da, ra);
      n_checks++; if (lat !== 17) $display("FAIL dir%0d_latency: got %0d want 17", i, lat); else n_pass++;
      n_checks++; if (prod !== expv) $display("FAIL dir%0d_product: got %h want %h", i, prod, expv); else n_pass++;
      n_checks++; if (da !== 1'b0 || ra !== 1'b1) $display("FAIL dir%0d_pulse: done=%b ready=%b want 0 1", i, da, ra); else n_pass++;
      n_checks++; if (!held || !bok) $display("FAIL dir%0d_run_outputs: held=%0d busy=%0d want 1 1", i, held, bok); else n_pass++;
      last16 = expv;
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] prod; bit held, bok; logic da, ra;
    sel = 1'b0;
    do_mul(16'd3, 16'd5, last16, 1'b1, lat, prod, held, bok, da, ra);
    n_checks++; if (prod !== 32'd15) $display("FAIL ignore_product: got %0d want 15", prod); else n_pass++;
    n_checks++; if (lat !== 17) $display("FAIL ignore_latency: got %0d want 17", lat); else n_pass++;
    n_checks++; if (da !== 1'b0 || ra !== 1'b1) $display("FAIL ignore_pulse: done=%b ready=%b want 0 1", da, ra); else n_pass++;
    last16 = 32'd15;
    do_mul(16'd9, 16'd9, last16, 1'b0, lat, prod, held, bok, da, ra);
    n_checks++; if (!held) $display("FAIL b2b_held: product changed before done, want 15 held"); else n_pass++;
    n_checks++; if (prod !== 32'd81) $display("FAIL b2b_product: got %0d want 81", prod); else n_pass++;
    n_checks++; if (lat !== 17) $display("FAIL b2b_latency: got %0d want 17", lat); else n_pass++;
    last16 = 32'd81;
  endtask

  task automatic test_reset_midrun;
    int lat; logic [31:0] prod; bit held, bok; logic da, ra;
    sel = 1'b0;
    a = 16'd100; b = 16'd100; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (7) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_checks++; if (r16 !== 1'b1 || bz16 !== 1'b0 || d16 !== 1'b0)
      $display("FAIL midrst_flags: ready=%b busy=%b done=%b want 1 0 0", r16, bz16, d16); else n_pass++;
    n_checks++; if (p16 !== 32'h0) $display("FAIL midrst_product: got %h want 0", p16); else n_pass++;
    last16 = '0;
    do_mul(16'd4, 16'd4, last16, 1'b0, lat, prod, held, bok, da, ra);
    n_checks++; if (prod !== 32'd16) $display("FAIL midrst_next_product: got %0d want 16", prod); else n_pass++;
    n_checks++; if (lat !== 17) $display("FAIL midrst_next_latency: got %0d want 17", lat); else n_pass++;
    last16 = 32'd16;
  endtask

  task automatic test_random;
    int lat; logic [31:0] prod, expv; bit held, bok; logic da, ra;
    logic [15:0] ra_v, rb_v;
    sel = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ra_v = 16'($urandom); rb_v = 16'($urandom);
      if (i == 0) ra_v = 16'h8000;
      expv = ref_mul(ra_v, rb_v, 1'b0);
      repeat ($urandom_range(0, 2)) tick;
      do_mul(ra_v, rb_v, last16, (i % 3) == 1, lat, prod, held, bok, da, ra);
      n_checks++; if (prod !== expv || lat !== 17 || !held)
        $display("FAIL rand%0d: %h*%h got %h lat %0d held %0d want %h lat 17 held 1", i, ra_v, rb_v, prod, lat, held, expv); else n_pass++;
      last16 = expv;
    end
  endtask

  task automatic test_w1;
    logic [15:0] ta [4] = '{16'd1, 16'd1, 16'd0, 16'd1};
    logic [15:0] tb [4] = '{16'd1, 16'd0, 16'd1, 16'd1};
    int lat; logic [31:0] prod, expv; bit held, bok; logic da, ra;
    sel = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      expv = ref_mul(ta[i], tb[i], 1'b1);
      do_mul(ta[i], tb[i], last1, 1'b0, lat, prod, held, bok, da, ra);
      n_checks++; if (lat !== 2) $display("FAIL w1_%0d_latency: got %0d want 2", i, lat); else n_pass++;
      n_checks++; if (prod !== expv) $display("FAIL w1_%0d_product: got %h want %h", i, prod, expv); else n_pass++;
      n_checks++; if (da !== 1'b0 || ra !== 1'b1) $display("FAIL w1_%0d_pulse: done=%b ready=%b want 0 1", i, da, ra); else n_pass++;
      last1 = expv;
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_reset_midrun;
    test_random;
    test_w1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
